// File: rtl/bridge_reg_bank.sv
// Bank of bridge-mapped 32-bit configuration registers with per-bit write masks
// and an optional shadow/commit stage in front of the live outputs to the core.
module bridge_reg_bank #(
    parameter logic [31:0] BASE_ADDR              = 32'h0010_0000,
    parameter int          NUM_REGS               = 4,
    parameter logic [31:0] DEFAULTS   [NUM_REGS]  = '{default: 32'h0000_0000},
    parameter logic [31:0] WRITE_MASK [NUM_REGS]  = '{default: 32'hFFFF_FFFF},
    parameter bit          SHADOWED               = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  bridge_addr,
    input  logic                         bridge_wr,
    input  logic [31:0]                  bridge_wr_data,
    input  logic                         bridge_rd,
    output logic [31:0]                  bridge_rd_data,
    output logic                         rd_hit,
    input  logic                         commit_req,
    output logic [NUM_REGS-1:0][31:0]    regs_live,
    output logic [NUM_REGS-1:0]          regs_changed,
    output logic                         commit_pending
);

    localparam int          IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [31:0] REG_SPAN = 32'(4 * NUM_REGS);

    logic [31:0]                offset;
    logic [IDX_W-1:0]           idx;
    logic                       reg_hit;
    logic                       ctrl_hit;
    logic                       ctrl_wr;
    logic                       commit;
    logic                       revert;
    logic [NUM_REGS-1:0][31:0]  shadow;
    logic [NUM_REGS-1:0][31:0]  shadow_next;
    logic [NUM_REGS-1:0][31:0]  live_next;
    logic [7:0]                 commit_cnt;
    logic [31:0]                rd_data_next;
    logic                       unused_rd;

    // Unsigned wrap makes addresses below BASE_ADDR fall out of range too.
    assign offset    = bridge_addr - BASE_ADDR;
    assign idx       = offset[IDX_W+1:2];
    assign reg_hit   = (offset[1:0] == 2'b00) && (offset < REG_SPAN);
    assign ctrl_hit  = SHADOWED && (offset == REG_SPAN);
    assign ctrl_wr   = bridge_wr && ctrl_hit;
    assign commit    = SHADOWED && (commit_req || (ctrl_wr && bridge_wr_data[0]));
    assign revert    = ctrl_wr && bridge_wr_data[1] && !bridge_wr_data[0];
    assign unused_rd = bridge_rd;

    always_comb begin
        shadow_next    = shadow;
        live_next      = regs_live;
        commit_pending = 1'b0;
        rd_data_next   = 32'h0000_0000;
        for (int i = 0; i < NUM_REGS; i++) begin
            // Commit samples the old shadow; a same-cycle write lands after it.
            if (commit)
                live_next[i] = shadow[i];
            if (revert)
                shadow_next[i] = regs_live[i];
            if (bridge_wr && reg_hit && (idx == IDX_W'(i)))
                shadow_next[i] = (shadow[i] & ~WRITE_MASK[i]) | (bridge_wr_data & WRITE_MASK[i]);
            if (!SHADOWED)
                live_next[i] = shadow_next[i];
            if (shadow[i] != regs_live[i])
                commit_pending = 1'b1;
            if (reg_hit && (idx == IDX_W'(i)))
                rd_data_next = shadow[i];
        end
        if (ctrl_hit)
            rd_data_next = {16'h0000, commit_cnt, 7'h00, commit_pending};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i]    <= DEFAULTS[i];
                regs_live[i] <= DEFAULTS[i];
            end
            regs_changed   <= '0;
            bridge_rd_data <= 32'h0000_0000;
            rd_hit         <= 1'b0;
            commit_cnt     <= 8'h00;
        end else begin
            shadow    <= shadow_next;
            regs_live <= live_next;
            for (int i = 0; i < NUM_REGS; i++)
                regs_changed[i] <= (live_next[i] != regs_live[i]);
            bridge_rd_data <= rd_data_next;
            rd_hit         <= reg_hit || ctrl_hit;
            if (commit)
                commit_cnt <= commit_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_bridge_reg_bank.sv
// Directed bench for bridge_reg_bank: two shadowed banks sharing one bridge
// (plain and masked/defaulted reg0) plus a single-register direct-write bank.
module tb_bridge_reg_bank;

    localparam logic [31:0] BASE = 32'h0010_0000;
    localparam logic [31:0] CTRL = BASE + 32'd16;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [31:0] addr = 32'h0;
    logic        wr = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic        rd = 1'b0;
    logic        commit_req = 1'b0;

    logic [31:0]      a_rd_data, b_rd_data;
    logic             a_rd_hit, b_rd_hit;
    logic [3:0][31:0] a_live, b_live;
    logic [3:0]       a_changed, b_changed;
    logic             a_pending, b_pending;

    logic [31:0]      c_addr = 32'h0;
    logic             c_wr = 1'b0;
    logic [31:0]      c_wr_data = 32'h0;
    logic             c_commit_req = 1'b0;
    logic [31:0]      c_rd_data;
    logic             c_rd_hit;
    logic [0:0][31:0] c_live;
    logic [0:0]       c_changed;
    logic             c_pending;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bridge_reg_bank u_dut_a (
        .clk(clk), .reset(reset), .bridge_addr(addr), .bridge_wr(wr),
        .bridge_wr_data(wr_data), .bridge_rd(rd), .bridge_rd_data(a_rd_data),
        .rd_hit(a_rd_hit), .commit_req(commit_req), .regs_live(a_live),
        .regs_changed(a_changed), .commit_pending(a_pending)
    );

    bridge_reg_bank #(
        .DEFAULTS('{32'h1234_5600, 32'h0, 32'h0, 32'h0}),
        .WRITE_MASK('{32'h0000_00FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF})
    ) u_dut_b (
        .clk(clk), .reset(reset), .bridge_addr(addr), .bridge_wr(wr),
        .bridge_wr_data(wr_data), .bridge_rd(rd), .bridge_rd_data(b_rd_data),
        .rd_hit(b_rd_hit), .commit_req(commit_req), .regs_live(b_live),
        .regs_changed(b_changed), .commit_pending(b_pending)
    );

    bridge_reg_bank #(.NUM_REGS(1), .SHADOWED(1'b0)) u_dut_c (
        .clk(clk), .reset(reset), .bridge_addr(c_addr), .bridge_wr(c_wr),
        .bridge_wr_data(c_wr_data), .bridge_rd(1'b1), .bridge_rd_data(c_rd_data),
        .rd_hit(c_rd_hit), .commit_req(c_commit_req), .regs_live(c_live),
        .regs_changed(c_changed), .commit_pending(c_pending)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wr_data = d; wr = 1'b1; rd = 1'b0;
        tick();
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        addr = a; rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic pulse_commit();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        bus_read(BASE);
        n_cmp++; if (a_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd: got %h want %h", a_rd_data, 32'h0); end
        n_cmp++; if (a_rd_hit !== 1'b1) begin n_fail++; $display("FAIL reset_hit: got %b want 1", a_rd_hit); end
        n_cmp++; if (a_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", a_pending); end
        n_cmp++; if (a_live !== '0) begin n_fail++; $display("FAIL reset_live: got %h want 0", a_live); end
        n_cmp++; if (b_rd_data !== 32'h1234_5600) begin n_fail++; $display("FAIL reset_b_default: got %h want %h", b_rd_data, 32'h1234_5600); end
        n_cmp++; if (b_live[0] !== 32'h1234_5600) begin n_fail++; $display("FAIL reset_b_live: got %h want %h", b_live[0], 32'h1234_5600); end
    endtask

    task automatic test_shadow_commit();
        bus_write(BASE + 32'd4, 32'hDEAD_BEEF);
        n_cmp++; if (a_live[1] !== 32'h0) begin n_fail++; $display("FAIL shadow_live_held: got %h want 0", a_live[1]); end
        n_cmp++; if (a_pending !== 1'b1) begin n_fail++; $display("FAIL shadow_pending: got %b want 1", a_pending); end
        bus_read(BASE + 32'd4);
        n_cmp++; if (a_rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL shadow_readback: got %h want %h", a_rd_data, 32'hDEAD_BEEF); end
        pulse_commit();
        n_cmp++; if (a_live[1] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL commit_live: got %h want %h", a_live[1], 32'hDEAD_BEEF); end
        n_cmp++; if (a_changed !== 4'b0010) begin n_fail++; $display("FAIL commit_changed: got %b want 0010", a_changed); end
        tick();
        n_cmp++; if (a_changed !== 4'b0000) begin n_fail++; $display("FAIL commit_changed_1cyc: got %b want 0000", a_changed); end
        bus_read(CTRL);
        n_cmp++; if (a_rd_data !== 32'h0000_0100) begin n_fail++; $display("FAIL ctrl_after_commit: got %h want %h", a_rd_data, 32'h0000_0100); end
    endtask

    task automatic test_write_mask();
        bus_write(BASE, 32'hFFFF_FFFF);
        bus_read(BASE);
        n_cmp++; if (b_rd_data !== 32'h1234_56FF) begin n_fail++; $display("FAIL mask_b_read: got %h want %h", b_rd_data, 32'h1234_56FF); end
        n_cmp++; if (a_rd_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mask_a_read: got %h want %h", a_rd_data, 32'hFFFF_FFFF); end
        pulse_commit();
        n_cmp++; if (b_live[0] !== 32'h1234_56FF) begin n_fail++; $display("FAIL mask_b_live: got %h want %h", b_live[0], 32'h1234_56FF); end
        n_cmp++; if (b_changed !== 4'b0001) begin n_fail++; $display("FAIL mask_b_changed: got %b want 0001", b_changed); end
        n_cmp++; if (a_changed !== 4'b0001) begin n_fail++; $display("FAIL mask_a_changed: got %b want 0001", a_changed); end
    endtask

    task automatic test_same_cycle();
        addr = BASE + 32'd8; wr_data = 32'hCAFE_F00D; wr = 1'b1; commit_req = 1'b1;
        tick();
        wr = 1'b0; commit_req = 1'b0;
        n_cmp++; if (a_live[2] !== 32'h0) begin n_fail++; $display("FAIL same_live_old: got %h want 0", a_live[2]); end
        n_cmp++; if (a_pending !== 1'b1) begin n_fail++; $display("FAIL same_pending: got %b want 1", a_pending); end
        n_cmp++; if (a_changed !== 4'b0000) begin n_fail++; $display("FAIL same_changed: got %b want 0000", a_changed); end
        bus_read(BASE + 32'd8);
        n_cmp++; if (a_rd_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL same_shadow: got %h want %h", a_rd_data, 32'hCAFE_F00D); end
        bus_read(CTRL);
        n_cmp++; if (a_rd_data !== 32'h0000_0301) begin n_fail++; $display("FAIL same_ctrl: got %h want %h", a_rd_data, 32'h0000_0301); end
    endtask

    task automatic test_revert_ctrl();
        bus_write(CTRL, 32'h2);
        n_cmp++; if (a_pending !== 1'b0) begin n_fail++; $display("FAIL revert_pending: got %b want 0", a_pending); end
        n_cmp++; if (a_changed !== 4'b0000) begin n_fail++; $display("FAIL revert_changed: got %b want 0000", a_changed); end
        bus_read(BASE + 32'd8);
        n_cmp++; if (a_rd_data !== 32'h0) begin n_fail++; $display("FAIL revert_shadow: got %h want 0", a_rd_data); end
        bus_write(BASE + 32'd12, 32'h5555_AAAA);
        bus_write(CTRL, 32'h3);
        n_cmp++; if (a_live[3] !== 32'h5555_AAAA) begin n_fail++; $display("FAIL ctrl11_live: got %h want %h", a_live[3], 32'h5555_AAAA); end
        n_cmp++; if (a_changed !== 4'b1000) begin n_fail++; $display("FAIL ctrl11_changed: got %b want 1000", a_changed); end
        n_cmp++; if (a_pending !== 1'b0) begin n_fail++; $display("FAIL ctrl11_pending: got %b want 0", a_pending); end
        bus_read(CTRL);
        n_cmp++; if (a_rd_data !== 32'h0000_0400) begin n_fail++; $display("FAIL ctrl11_cnt: got %h want %h", a_rd_data, 32'h0000_0400); end
        addr = CTRL; wr_data = 32'h1; wr = 1'b1; commit_req = 1'b1;
        tick();
        wr = 1'b0; commit_req = 1'b0;
        bus_read(CTRL);
        n_cmp++; if (a_rd_data !== 32'h0000_0500) begin n_fail++; $display("FAIL dual_commit_cnt: got %h want %h", a_rd_data, 32'h0000_0500); end
    endtask

    task automatic test_out_of_range();
        bus_write(BASE + 32'd2, 32'hFFFF_0000);
        bus_read(BASE + 32'd2);
        n_cmp++; if (a_rd_hit !== 1'b0) begin n_fail++; $display("FAIL unaligned_hit: got %b want 0", a_rd_hit); end
        n_cmp++; if (a_rd_data !== 32'h0) begin n_fail++; $display("FAIL unaligned_rd: got %h want 0", a_rd_data); end
        n_cmp++; if (a_pending !== 1'b0) begin n_fail++; $display("FAIL unaligned_wr_ignored: got %b want 0", a_pending); end
        bus_write(BASE + 32'd20, 32'h0000_0001);
        bus_read(BASE + 32'd20);
        n_cmp++; if (a_rd_hit !== 1'b0) begin n_fail++; $display("FAIL beyond_hit: got %b want 0", a_rd_hit); end
        n_cmp++; if (a_rd_data !== 32'h0) begin n_fail++; $display("FAIL beyond_rd: got %h want 0", a_rd_data); end
        bus_read(BASE - 32'd4);
        n_cmp++; if (a_rd_hit !== 1'b0) begin n_fail++; $display("FAIL below_hit: got %b want 0", a_rd_hit); end
        bus_read(BASE);
        n_cmp++; if (a_rd_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reg0_intact: got %h want %h", a_rd_data, 32'hFFFF_FFFF); end
        n_cmp++; if (a_pending !== 1'b0) begin n_fail++; $display("FAIL range_pending: got %b want 0", a_pending); end
    endtask

    task automatic test_cnt_wrap();
        addr = 32'h0;
        commit_req = 1'b1;
        for (int i = 0; i < 251; i++) tick();
        commit_req = 1'b0;
        bus_read(CTRL);
        n_cmp++; if (a_rd_data !== 32'h0000_0000) begin n_fail++; $display("FAIL cnt_wrap: got %h want 0", a_rd_data); end
        pulse_commit();
        bus_read(CTRL);
        n_cmp++; if (a_rd_data !== 32'h0000_0100) begin n_fail++; $display("FAIL cnt_after_wrap: got %h want %h", a_rd_data, 32'h0000_0100); end
    endtask

    task automatic test_direct_mode();
        c_addr = BASE; c_wr_data = 32'hA5A5_0000; c_wr = 1'b1;
        tick();
        c_wr = 1'b0;
        n_cmp++; if (c_live[0] !== 32'hA5A5_0000) begin n_fail++; $display("FAIL direct_live: got %h want %h", c_live[0], 32'hA5A5_0000); end
        n_cmp++; if (c_changed !== 1'b1) begin n_fail++; $display("FAIL direct_changed: got %b want 1", c_changed); end
        n_cmp++; if (c_pending !== 1'b0) begin n_fail++; $display("FAIL direct_pending: got %b want 0", c_pending); end
        tick();
        n_cmp++; if (c_changed !== 1'b0) begin n_fail++; $display("FAIL direct_changed_1cyc: got %b want 0", c_changed); end
        c_wr = 1'b1;
        tick();
        c_wr = 1'b0;
        n_cmp++; if (c_changed !== 1'b0) begin n_fail++; $display("FAIL direct_same_value: got %b want 0", c_changed); end
        c_addr = BASE + 32'd4; c_commit_req = 1'b1;
        tick();
        c_commit_req = 1'b0;
        n_cmp++; if (c_rd_hit !== 1'b0) begin n_fail++; $display("FAIL direct_no_ctrl: got %b want 0", c_rd_hit); end
        c_addr = BASE;
        tick();
        n_cmp++; if (c_rd_data !== 32'hA5A5_0000) begin n_fail++; $display("FAIL direct_read: got %h want %h", c_rd_data, 32'hA5A5_0000); end
    endtask

    task automatic test_mid_reset();
        addr = BASE + 32'd4; wr_data = 32'h1111_1111; wr = 1'b1; commit_req = 1'b1; reset = 1'b1;
        tick();
        wr = 1'b0; commit_req = 1'b0; reset = 1'b0;
        n_cmp++; if (a_live !== '0) begin n_fail++; $display("FAIL midrst_live: got %h want 0", a_live); end
        n_cmp++; if (a_rd_hit !== 1'b0) begin n_fail++; $display("FAIL midrst_hit: got %b want 0", a_rd_hit); end
        n_cmp++; if (c_live[0] !== 32'h0) begin n_fail++; $display("FAIL midrst_c_live: got %h want 0", c_live[0]); end
        bus_read(CTRL);
        n_cmp++; if (a_rd_data !== 32'h0) begin n_fail++; $display("FAIL midrst_ctrl: got %h want 0", a_rd_data); end
        bus_read(BASE + 32'd4);
        n_cmp++; if (a_rd_data !== 32'h0) begin n_fail++; $display("FAIL midrst_shadow: got %h want 0", a_rd_data); end
    endtask

    initial begin
        test_reset();
        test_shadow_commit();
        test_write_mask();
        test_same_cycle();
        test_revert_ctrl();
        test_out_of_range();
        test_cnt_wrap();
        test_direct_mode();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
